// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined multiply-accumulate for the convolution and
// fully-connected layer datapaths. Operands enter an input register, the
// product travels through NUM_STAGE-1 product registers, and the
// accumulator folds the terms of one dot-product group. The result register
// is loaded on the same edge as the accumulator when the group's last term
// arrives. Valid/first/last markers travel alongside the data, so groups can
// follow each other back to back. ce=0 freezes every register; reset
// (synchronous, active-high) overrides ce and discards anything in flight.
module cnn_mac_pipe #(
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int ACC_WIDTH  = 32,
   parameter int NUM_STAGE  = 4,
   parameter int SIGNED     = 0,
   parameter int SATURATE   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [ACC_WIDTH-1:0]  dout,
   output logic                  ovf
);

   localparam int PW = din0_WIDTH + din1_WIDTH;

   logic [din0_WIDTH-1:0] a_q;
   logic [din1_WIDTH-1:0] b_q;
   logic [NUM_STAGE-1:0]  valid_sr;
   logic [NUM_STAGE-1:0]  first_sr;
   logic [NUM_STAGE-1:0]  last_sr;
   logic [PW-1:0]         prod;
   logic [PW-1:0]         prod_acc;
   logic [ACC_WIDTH-1:0]  term;
   logic [ACC_WIDTH:0]    sum_wide;
   logic                  add_ovf;
   logic [ACC_WIDTH-1:0]  acc_q;
   logic [ACC_WIDTH-1:0]  acc_next;
   logic                  sticky_q;
   logic                  sticky_next;
   logic                  acc_valid;
   logic                  acc_first;
   logic                  acc_last;

   // Input register for the operands, plus the marker shift registers that
   // keep valid/first/last aligned with the term they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         valid_sr <= '0;
         first_sr <= '0;
         last_sr  <= '0;
      end else if (ce) begin
         a_q         <= din0;
         b_q         <= din1;
         valid_sr[0] <= in_valid;
         first_sr[0] <= in_first;
         last_sr[0]  <= in_last;
         for (int i = 1; i < NUM_STAGE; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            first_sr[i] <= first_sr[i-1];
            last_sr[i]  <= last_sr[i-1];
         end
      end
   end

   // Full-width product of the registered operands; both operands are
   // widened to the product width first so the multiply is exact.
   always_comb begin
      prod = '0;
      if (SIGNED != 0) begin
         prod = PW'($signed(a_q)) * PW'($signed(b_q));
      end else begin
         prod = PW'(a_q) * PW'(b_q);
      end
   end

   generate
      if (NUM_STAGE > 1) begin : g_prod_pipe
         logic [PW-1:0] prod_q [NUM_STAGE-1];

         // Product registers that give the multiplier its pipeline depth.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NUM_STAGE - 1; i++) begin
                  prod_q[i] <= '0;
               end
            end else if (ce) begin
               prod_q[0] <= prod;
               for (int i = 1; i < NUM_STAGE - 1; i++) begin
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign prod_acc = prod_q[NUM_STAGE-2];
      end else begin : g_no_prod_pipe
         assign prod_acc = prod;
      end
   endgenerate

   assign acc_valid = valid_sr[NUM_STAGE-1];
   assign acc_first = first_sr[NUM_STAGE-1];
   assign acc_last  = last_sr[NUM_STAGE-1];

   // Extend the product to accumulator width, sign- or zero-filled.
   always_comb begin
      term = '0;
      if (SIGNED != 0) begin
         term = ACC_WIDTH'($signed(prod_acc));
      end else begin
         term = ACC_WIDTH'(prod_acc);
      end
   end

   // Next accumulator value: a first term restarts the group, any other term
   // is added one bit wider so overflow can be seen and clamped or wrapped.
   always_comb begin
      sum_wide    = '0;
      add_ovf     = 1'b0;
      acc_next    = acc_q;
      sticky_next = sticky_q;
      if (SIGNED != 0) begin
         sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};
         add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
      end else begin
         sum_wide = {1'b0, acc_q} + {1'b0, term};
         add_ovf  = sum_wide[ACC_WIDTH];
      end
      if (acc_valid) begin
         if (acc_first) begin
            acc_next    = term;
            sticky_next = 1'b0;
         end else begin
            if (add_ovf && (SATURATE != 0)) begin
               if (SIGNED != 0) begin
                  if (sum_wide[ACC_WIDTH]) begin
                     acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                  end else begin
                     acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
                  end
               end else begin
                  acc_next = '1;
               end
            end else begin
               acc_next = sum_wide[ACC_WIDTH-1:0];
            end
            sticky_next = sticky_q | add_ovf;
         end
      end
   end

   // Accumulator, sticky overflow flag and result register. The result is
   // captured from the new accumulator value on the group's last term and
   // held until the next group completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else if (ce) begin
         acc_q     <= acc_next;
         sticky_q  <= sticky_next;
         out_valid <= acc_valid & acc_last;
         if (acc_valid && acc_last) begin
            dout <= acc_next;
            ovf  <= sticky_next;
         end
      end
   end

endmodule

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Parametrised pipelined multiply-accumulate unit for the convolution and fully-connected layer datapaths. It generalises the fixed-latency layer multipliers in three ways: pipeline depth is a parameter, operands can be signed or unsigned, and valid/first/last markers travel through the pipe so a whole dot-product group is accumulated in place. One result is emitted per group, with optional saturation and a sticky overflow flag. Throughput is one product term per enabled cycle.

## Interface
- din0_WIDTH, 14, operand A width
- din1_WIDTH, 12, operand B width
- ACC_WIDTH, 32, accumulator/result width; must be ≥ din0_WIDTH+din1_WIDTH
- NUM_STAGE, 4, multiplier pipeline registers including input register; ≥ 1
- SIGNED, 0, 1 = operands and result two's complement; 0 = unsigned
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- ce  in  1  clock enable; 0 freezes every register except under reset
- in_valid  in  1  beat carries a product term
- in_first  in  1  first term of a group; meaningful only with in_valid
- in_last  in  1  last term of a group; meaningful only with in_valid
- din0  in  din0_WIDTH  operand A
- din1  in  din1_WIDTH  operand B
- out_valid  out  1  dout/ovf hold a completed group result
- dout  out  ACC_WIDTH  group sum
- ovf  out  1  overflow occurred in the group now on dout

## Operation
- Beat accepted on an edge with ce=1 and in_valid=1. in_valid=0 beats pass as bubbles and never touch the accumulator.
- Product P = din0*din1, width din0_WIDTH+din1_WIDTH.
  - SIGNED=1: both operands signed.
  - SIGNED=0: both zero-extended.
  - P is sign- or zero-extended to ACC_WIDTH.
- valid, first and last shift alongside data through NUM_STAGE registers.
- Accumulate stage, on a valid beat:
  - first=1: acc ← ext(P).
  - first=0: acc ← acc + ext(P), computed one bit wider.
- Overflow on the add:
  - Detected when the result is not representable in ACC_WIDTH (signed or unsigned range per SIGNED).
  - SATURATE=1: clamp to the max/min of the range (unsigned max = all ones, min = 0).
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - The group's ovf bit is set in either mode. It is cleared by a first beat unless that beat itself overflows (it cannot).
- Last beat at the accumulate stage: the next registered outputs are out_valid=1, dout=new acc value, ovf=group sticky flag.
  - Otherwise out_valid=0 on that enabled edge.
  - dout and ovf hold the last result.
- first=1 and last=1 on the same beat: single-term group, dout=ext(P).
- A group lacking first continues from the stale acc (caller error, defined behaviour).
- A new first may immediately follow a last; groups need no gap.

## Timing
- Latency is counted in ce=1 edges. From the edge that accepts a last beat to the edge that sets out_valid is NUM_STAGE+1 edges (5 at defaults).
- Stages:
  - Input register.
  - NUM_STAGE−1 product registers.
  - Accumulator register.
  - Output register loaded together with the accumulator.
- ce=0: all registers hold, including out_valid, dout and ovf. Consumers count a result on each edge where ce=1 and out_valid=1. A pulse therefore spans exactly one enabled edge regardless of stalls.
- Reset (overrides ce): all valid/first/last flags, acc, the sticky flag, out_valid, dout and ovf go to 0 on the next edge. Any group in flight is discarded; the first post-reset result contains only post-reset terms.
- Inputs are not required stable while ce=0; they are sampled only on enabled edges.

## Test plan
- SIGNED=0, defaults: one beat din0=16383, din1=4095, first=last=1 → out_valid after 5 enabled edges, dout=67088385, ovf=0.
- SIGNED=1: beats (−3,5) first, (7,−2), (100,4) last → single out_valid, dout=371, ovf=0; no out_valid on intermediate beats.
- Repeat the previous case with ce=0 for 3 cycles mid-pipe → result 3 cycles later, dout=371, out_valid counted once.
- din widths 10/10, ACC_WIDTH=20, SIGNED=0: two beats 1023×1023 → SATURATE=1: dout=1048575, ovf=1; SATURATE=0: dout=1044482, ovf=1. A following single-term group 2×3 → dout=6, ovf=0.
- Reset after 2 beats of a 4-beat group, then new group (2,2),(3,3) → no out_valid from the aborted group; result dout=13.
- Four consecutive beats each first=last=1 with products 1,2,3,4 → out_valid on 4 consecutive edges, dout=1,2,3,4.
